// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU data accesses onto a sync data RAM and
// on-board registers (LED, 7-seg, switches, down-counting interrupt timer).
module mio_bus_ctrl #(
  parameter int RAM_AW    = 10,
  parameter int TIMER_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              mio_ready,
  output logic              int_out,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [31:0]       seg_out
);

  localparam logic [31:0] SEG_ADDR = 32'hE000_0000;
  localparam logic [31:0] IO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] TMR_ADDR = 32'hF000_0004;
  localparam int          PW       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          ram_hit, seg_hit, io_hit, tmr_hit;
  logic          accept, wr;
  logic [31:0]   io_rdata;
  logic [31:0]   count;
  logic [PW-1:0] presc;
  logic          tick;

  assign ram_hit = (cpu_addr >> (RAM_AW + 2)) == 32'd0;
  assign seg_hit = cpu_addr == SEG_ADDR;
  assign io_hit  = cpu_addr == IO_ADDR;
  assign tmr_hit = cpu_addr == TMR_ADDR;

  assign accept  = (state == IDLE) && cpu_req;
  assign wr      = accept && cpu_we;

  assign ram_addr  = cpu_addr[RAM_AW+1:2];
  assign ram_din   = cpu_wdata;
  // Only IDLE can strobe the RAM, so a request held high through RESP cannot double-write.
  assign ram_we    = wr && ram_hit;
  assign mio_ready = (state == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (ram_hit && !cpu_we) ? RAM_WAIT : RESP;
      RAM_WAIT: state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io_rdata = '0;
    if (seg_hit)      io_rdata = seg_out;
    else if (io_hit)  io_rdata = {16'h0, sw_in};
    else if (tmr_hit) io_rdata = count;
  end

  // Non-RAM reads capture at acceptance; RAM reads capture the cycle after the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             cpu_rdata <= '0;
    else if (accept && !cpu_we && !ram_hit) cpu_rdata <= io_rdata;
    else if (state == RAM_WAIT)             cpu_rdata <= ram_dout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
      seg_out <= '0;
    end else begin
      if (wr && io_hit)  led_out <= cpu_wdata[15:0];
      if (wr && seg_hit) seg_out <= cpu_wdata;
    end
  end

  assign tick = (presc == PW'(TIMER_DIV - 1));

  // A timer load overrides a same-cycle decrement and restarts the prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      presc   <= '0;
      int_out <= 1'b0;
    end else begin
      int_out <= 1'b0;
      if (wr && tmr_hit) begin
        count <= cpu_wdata;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && count != 32'd0) begin
          count   <= count - 32'd1;
          int_out <= (count == 32'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomized bench for mio_bus_ctrl against a transaction-level model of the
// address map, RAM contents and timer expiry schedule.
module tb_mio_bus_ctrl;

  localparam int RAM_AW    = 10;
  localparam int TIMER_DIV = 1;
  localparam logic [31:0] SEG = 32'hE000_0000;
  localparam logic [31:0] IO  = 32'hF000_0000;
  localparam logic [31:0] TMR = 32'hF000_0004;

  logic              clk = 0;
  logic              reset = 0;
  logic              cpu_req = 0, cpu_we = 0;
  logic [31:0]       cpu_addr = 0, cpu_wdata = 0;
  logic [31:0]       cpu_rdata;
  logic              mio_ready, int_out;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic              ram_we;
  logic [31:0]       ram_dout;
  logic [15:0]       sw_in = 0;
  logic [15:0]       led_out;
  logic [31:0]       seg_out;

  mio_bus_ctrl #(.RAM_AW(RAM_AW), .TIMER_DIV(TIMER_DIV)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .mio_ready(mio_ready), .int_out(int_out), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .sw_in(sw_in),
    .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous write, one-cycle registered read
  logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] exp_led = 0, exp_seg = 0, exp_rdata = 0;
  bit          have_tmr = 0;
  longint      tmr_val = 0, tmr_edge = 0, exp_pulse = -1;
  longint      cyc = 0;
  int          n_we_exp = 0, n_we_seen = 0;
  int          n_vec = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Timer value just after posedge number e
  function automatic logic [31:0] tmr_at(input longint e);
    longint d;
    if (!have_tmr) return 0;
    d = (e - tmr_edge) / TIMER_DIV;
    return (tmr_val > d) ? 32'(tmr_val - d) : 32'd0;
  endfunction

  always @(negedge clk) begin
    chk("int_out", {31'b0, int_out}, {31'b0, cyc == exp_pulse});
    if (ram_we) n_we_seen++;
  end

  // Model update at acceptance edge acc
  task automatic model_accept(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input longint acc);
    bit ram;
    ram = (addr[31:12] == 0);
    if (we) begin
      if (ram) begin ref_mem[int'(addr[11:2])] = wd; n_we_exp++; end
      else if (addr == SEG) exp_seg = wd;
      else if (addr == IO)  exp_led = {16'h0, wd[15:0]};
      else if (addr == TMR) begin
        have_tmr = 1; tmr_val = longint'(wd); tmr_edge = acc;
        exp_pulse = (wd != 0) ? acc + longint'(wd) * TIMER_DIV : -1;
      end
    end else begin
      if (ram)              exp_rdata = ref_mem.exists(int'(addr[11:2])) ? ref_mem[int'(addr[11:2])] : 32'h0;
      else if (addr == SEG) exp_rdata = exp_seg;
      else if (addr == IO)  exp_rdata = {16'h0, sw_in};
      else if (addr == TMR) exp_rdata = tmr_at(acc - 1);
      else                  exp_rdata = 0;
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [15:0] sw);
    int lat;
    bit ram;
    ram = (addr[31:12] == 0);
    @(posedge clk); #1;
    sw_in = sw; cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    chk("ram_we", {31'b0, ram_we}, {31'b0, ram && we});
    if (ram) chk("ram_addr", {22'b0, ram_addr}, {22'b0, addr[11:2]});
    if (ram && we) chk("ram_din", ram_din, wd);
    #1;
    model_accept(we, addr, wd, cyc + 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mio_ready && lat < 8);
    chk("latency", lat, (ram && !we) ? 2 : 1);
    cpu_req = 0;
    chk("rdata", cpu_rdata, exp_rdata);
    chk("led", {16'h0, led_out}, exp_led);
    chk("seg", seg_out, exp_seg);
    @(negedge clk);
    chk("ready_pulse", {31'b0, mio_ready}, 32'd0);
  endtask

  task automatic model_reset();
    exp_led = 0; exp_seg = 0; exp_rdata = 0;
    have_tmr = 0; exp_pulse = -1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_ready"}, {31'b0, mio_ready}, 0);
    chk({tag, "_led"}, {16'h0, led_out}, 0);
    chk({tag, "_seg"}, seg_out, 0);
    chk({tag, "_int"}, {31'b0, int_out}, 0);
  endtask

  initial begin
    int gap;
    logic [31:0] a;
    logic [31:0] unmapped [5];
    unmapped = '{32'h8000_0000, 32'h0000_1000, 32'hE000_0004, 32'hF000_0008, 32'h1234_5670};

    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_ram_we", {31'b0, ram_we}, 0);
    #1 reset = 1;

    access(1, 32'h10, 32'h1234_5678, 16'h0);
    access(0, 32'h10, 32'h0, 16'h0);
    access(1, IO, 32'h0000_ABCD, 16'h0);
    access(0, IO, 32'h0, 16'h5A5A);
    access(1, SEG, 32'hDEAD_BEEF, 16'h0);
    access(0, SEG, 32'h0, 16'h0);
    access(1, TMR, 32'd3, 16'h0);
    repeat (8) @(negedge clk);
    access(0, TMR, 32'h0, 16'h0);
    access(1, TMR, 32'd0, 16'h0);
    repeat (4) @(negedge clk);
    access(0, 32'h8000_0000, 32'h0, 16'h0);
    access(1, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0);
    access(0, SEG, 32'h0, 16'h0);

    // Back-to-back writes with cpu_req held high throughout
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hAAAA_0001;
    @(negedge clk); #1;
    model_accept(1, 32'h20, 32'hAAAA_0001, cyc + 1);
    gap = 0;
    do begin @(negedge clk); gap++; end while (!mio_ready && gap < 8);
    chk("b2b_lat1", gap, 1);
    chk("b2b_resp_we", {31'b0, ram_we}, 0);
    cpu_addr = 32'h24; cpu_wdata = 32'hAAAA_0002;
    @(negedge clk);
    chk("b2b_idle_we", {31'b0, ram_we}, 1);
    #1 model_accept(1, 32'h24, 32'hAAAA_0002, cyc + 1);
    gap = 1;
    do begin @(negedge clk); gap++; end while (!mio_ready && gap < 8);
    chk("b2b_gap", gap, 2);
    cpu_req = 0;
    access(0, 32'h20, 32'h0, 16'h0);
    access(0, 32'h24, 32'h0, 16'h0);

    // Reset while a RAM read sits in RAM_WAIT
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk); @(negedge clk);
    chk("rw_ready", {31'b0, mio_ready}, 0);
    #1 reset = 0; cpu_req = 0;
    model_reset();
    #1 check_zero("midreset");
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {31'b0, mio_ready}, 0);
    end
    #1 reset = 1;
    access(0, TMR, 32'h0, 16'h0);
    access(0, 32'h10, 32'h0, 16'h0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0, 1: access(1, {20'h0, 6'h0, 4'($urandom), 2'b00}, $urandom, 16'($urandom));
        2: begin
          a = {20'h0, 6'h0, 4'($urandom), 2'b00};
          access(!ref_mem.exists(int'(a[11:2])), a, $urandom, 16'($urandom));
        end
        3: access(1'($urandom), SEG, $urandom, 16'($urandom));
        4: access(1'($urandom), IO, $urandom, 16'($urandom));
        5: access(1'($urandom), TMR, 32'($urandom_range(0, 12)), 16'($urandom));
        default: access(1'($urandom), unmapped[$urandom_range(0, 4)], $urandom, 16'($urandom));
      endcase
    end

    repeat (3) @(negedge clk);
    chk("ram_we_total", n_we_seen, n_we_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
